// File: rtl/color_threshold_pipe.sv
// Two-stage per-pixel colour threshold with frame-aligned double-buffered
// configuration and a saturating per-frame hit counter.
module color_threshold_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 3,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         pixel_valid_in,
  input  logic                         sof_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] pixel_in,
  input  logic                         cfg_wr_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] cfg_lo_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] cfg_hi_in,
  input  logic [2*NUM_CH-1:0]          cfg_mode_in,
  input  logic                         cfg_invert_in,
  output logic                         cfg_pending_out,
  output logic                         mask_valid_out,
  output logic                         mask_out,
  output logic                         mask_sof_out,
  output logic                         count_valid_out,
  output logic [COUNT_WIDTH-1:0]       count_out
);

  localparam int PW = NUM_CH * DATA_WIDTH;
  localparam int MW = 2 * NUM_CH;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_IGNORE  = 2'b00,
    MODE_INSIDE  = 2'b01,
    MODE_OUTSIDE = 2'b10,
    MODE_ABOVE   = 2'b11
  } mode_e;

  logic [PW-1:0]     act_lo, act_hi, pend_lo, pend_hi;
  logic [MW-1:0]     act_mode, pend_mode;
  logic              act_inv, pend_inv;

  logic              promote;
  logic [PW-1:0]     sel_lo, sel_hi;
  logic [MW-1:0]     sel_mode;
  logic              sel_inv;
  logic [NUM_CH-1:0] pass_d;

  logic [NUM_CH-1:0] s1_pass;
  logic              s1_valid, s1_sof, s1_inv;
  logic              mask_d;

  logic [COUNT_WIDTH-1:0] acc;
  logic                   frame_seen;

  // The SOF pixel that promotes the pending set is itself judged by it.
  always_comb begin
    promote  = pixel_valid_in & sof_in & cfg_pending_out;
    sel_lo   = promote ? pend_lo   : act_lo;
    sel_hi   = promote ? pend_hi   : act_hi;
    sel_mode = promote ? pend_mode : act_mode;
    sel_inv  = promote ? pend_inv  : act_inv;
    pass_d   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case (mode_e'(sel_mode[2*c +: 2]))
        MODE_IGNORE:  pass_d[c] = 1'b1;
        MODE_INSIDE:  pass_d[c] = (pixel_in[c*DATA_WIDTH +: DATA_WIDTH] >= sel_lo[c*DATA_WIDTH +: DATA_WIDTH]) &&
                                  (pixel_in[c*DATA_WIDTH +: DATA_WIDTH] <= sel_hi[c*DATA_WIDTH +: DATA_WIDTH]);
        MODE_OUTSIDE: pass_d[c] = (pixel_in[c*DATA_WIDTH +: DATA_WIDTH] <  sel_lo[c*DATA_WIDTH +: DATA_WIDTH]) ||
                                  (pixel_in[c*DATA_WIDTH +: DATA_WIDTH] >  sel_hi[c*DATA_WIDTH +: DATA_WIDTH]);
        MODE_ABOVE:   pass_d[c] = (pixel_in[c*DATA_WIDTH +: DATA_WIDTH] >  sel_lo[c*DATA_WIDTH +: DATA_WIDTH]);
        default:      pass_d[c] = 1'b1;
      endcase
    end
    mask_d = (&s1_pass) ^ s1_inv;
  end

  // A write in the same cycle as a promotion lands in pending after the copy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      act_lo          <= '0;
      act_hi          <= '1;
      act_mode        <= '0;
      act_inv         <= 1'b0;
      pend_lo         <= '0;
      pend_hi         <= '1;
      pend_mode       <= '0;
      pend_inv        <= 1'b0;
      cfg_pending_out <= 1'b0;
    end else begin
      if (promote) begin
        act_lo          <= pend_lo;
        act_hi          <= pend_hi;
        act_mode        <= pend_mode;
        act_inv         <= pend_inv;
        cfg_pending_out <= 1'b0;
      end
      if (cfg_wr_in) begin
        pend_lo         <= cfg_lo_in;
        pend_hi         <= cfg_hi_in;
        pend_mode       <= cfg_mode_in;
        pend_inv        <= cfg_invert_in;
        cfg_pending_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_pass  <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_inv   <= 1'b0;
    end else begin
      s1_pass  <= pass_d;
      s1_valid <= pixel_valid_in;
      s1_sof   <= pixel_valid_in & sof_in;
      s1_inv   <= sel_inv;
    end
  end

  // Count bookkeeping runs on the stage-2 inputs so the report lines up
  // with the SOF pixel's mask output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mask_valid_out  <= 1'b0;
      mask_out        <= 1'b0;
      mask_sof_out    <= 1'b0;
      count_valid_out <= 1'b0;
      count_out       <= '0;
      acc             <= '0;
      frame_seen      <= 1'b0;
    end else begin
      mask_valid_out  <= s1_valid;
      mask_out        <= mask_d;
      mask_sof_out    <= s1_sof;
      count_valid_out <= 1'b0;
      if (s1_valid) begin
        if (s1_sof) begin
          if (frame_seen) begin
            count_out       <= acc;
            count_valid_out <= 1'b1;
          end
          acc        <= COUNT_WIDTH'(mask_d);
          frame_seen <= 1'b1;
        end else if (mask_d && acc != CNT_MAX) begin
          acc <= acc + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/color_threshold_pipe.md
Name: color_threshold_pipe

Overview:
- Parametrised, pipelined per-pixel colour segmentation block for the camera video path.
- Compares each channel of a multi-channel pixel (e.g. Y/Cr/Cb) against a programmable lower/upper bound using a per-channel compare mode, and ANDs the per-channel results into a 1-bit mask.
- Configuration is double-buffered and becomes active only at a frame boundary, so a mask frame never mixes two configurations.
- Also reports, once per frame, the number of mask hits in the previous frame, for the downstream centroid/size logic.

Parameters:
- DATA_WIDTH, 8, bits per channel.
- NUM_CH, 3, number of channels per pixel; channel 0 occupies the LSBs of each packed bus.
- COUNT_WIDTH, 20, width of the per-frame hit counter.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- pixel_valid_in  input  1  pixel_in/sof_in are valid this cycle.
- sof_in  input  1  the current valid pixel is the first pixel of a frame; ignored when pixel_valid_in=0.
- pixel_in  input  NUM_CH*DATA_WIDTH  packed channel values.
- cfg_wr_in  input  1  one-cycle strobe; captures the cfg_* inputs into the pending registers.
- cfg_lo_in  input  NUM_CH*DATA_WIDTH  per-channel lower bound.
- cfg_hi_in  input  NUM_CH*DATA_WIDTH  per-channel upper bound.
- cfg_mode_in  input  2*NUM_CH  per-channel mode: 00 ignore, 01 inside, 10 outside, 11 above.
- cfg_invert_in  input  1  invert the final mask.
- cfg_pending_out  output  1  a written configuration is waiting for the next SOF.
- mask_valid_out  output  1  mask_out is valid.
- mask_out  output  1  threshold result.
- mask_sof_out  output  1  sof_in delayed and aligned with mask_out.
- count_valid_out  output  1  one-cycle pulse; count_out holds a new value.
- count_out  output  COUNT_WIDTH  number of mask=1 pixels in the previous frame.

Behaviour:
- Reset values: all outputs 0. Active config: lo=0, hi=all-ones, mode=00, invert=0 (every pixel passes). Pending config equals active; pending flag cleared; accumulator and frame_seen cleared.
- Per-channel compare, x=channel value, all comparisons unsigned:
  - 00 ignore: always pass.
  - 01 inside: pass when lo<=x<=hi (inclusive).
  - 10 outside: pass when x<lo or x>hi.
  - 11 above: pass when x>lo; hi is ignored.
  - If lo>hi, mode 01 never passes and mode 10 always passes. This is intentional and is not an error.
- mask = AND of all channel passes, XOR invert.
- Latency: exactly 2 cycles, fixed, no stalls.
  - Stage 1 registers the per-channel pass bits, valid and sof.
  - Stage 2 registers mask, valid and sof.
  - pixel_valid_in=0 produces mask_valid_out=0 two cycles later. mask_out and mask_sof_out are don't-care while invalid.
- Configuration update:
  - cfg_wr_in=1 copies all cfg_* inputs into the pending registers and sets cfg_pending_out on the next cycle.
  - A later write before the next SOF overwrites the pending values.
  - On an accepted SOF pixel (pixel_valid_in & sof_in) with pending set, pending is copied to active and the pending flag clears. The SOF pixel itself is evaluated with the new configuration (stage 1 selects pending when promoting).
  - If cfg_wr_in and an SOF pixel occur in the same cycle: the SOF pixel promotes the previously pending config (if any), or else uses the active config. The new write is stored as pending and cfg_pending_out stays 1.
- Hit count, evaluated at stage 2 output:
  - Each valid mask=1 adds 1 to the accumulator, saturating at 2^COUNT_WIDTH-1.
  - On a valid SOF at stage 2, when frame_seen=1: count_out <= accumulator value excluding the current pixel, and count_valid_out pulses for 1 cycle.
  - The accumulator is then reloaded with the current pixel's mask (0 or 1), and frame_seen is set.
  - The first SOF after reset emits no count.
  - Two consecutive SOF pixels are legal: the second reports a count of 0 or 1.
- Reset mid-frame: everything clears asynchronously, including in-flight pipeline data. No count is emitted for the interrupted frame.

Test Plan:
- After reset (no config written), drive 4 valid pixels with arbitrary values -> mask_out=1 for all 4, appearing exactly 2 cycles after each input; count_valid_out stays 0.
- Write lo={ch2=0x80, ch1=0x80, ch0=0x40}, hi=0xFF per channel, modes ch0=11, ch1=01, ch2=01, invert=0, mid-frame -> cfg_pending_out=1. Pixels keep the old config (mask=1) until the next SOF. The SOF pixel {0x90,0x90,0x50} gives mask=1; {0x90,0x70,0x50} gives mask=0.
- Same config with ch1 set to mode 10 and invert=1: pixel ch1=0x80 -> mask=1 (ch1 inside fails, AND=0, inverted); ch1=0x7F (all other channels passing) -> mask=0.
- Frame of 10 pixels with 7 hits, then SOF -> count_valid_out pulses once with count_out=7, aligned to the SOF pixel's stage-2 cycle. COUNT_WIDTH=3 with 9 hits -> count_out=7 (saturated).
- cfg_wr_in in the same cycle as an SOF pixel with no earlier pending write -> that frame uses the old config and cfg_pending_out=1. The following SOF promotes the new config and cfg_pending_out returns to 0.
- Assert rst_n_in for 1 cycle with 2 pixels in flight -> mask_valid_out=0 on the following cycles. The next SOF produces no count_valid_out pulse.
